// File: rtl/id_ex_operand_stage_if.sv
// Bus bundle between the decode stage, the ID/EX operand register and the
// downstream ALU/forwarding sources; the stage itself connects as the slave.
interface id_ex_operand_stage_if #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int CNT_W = 16
);
    // Decoded instruction presented by ID
    logic             id_valid;
    logic [XLEN-1:0]  id_pc;
    logic [XLEN-1:0]  id_rs1_data;
    logic [XLEN-1:0]  id_rs2_data;
    logic [XLEN-1:0]  id_imm;
    logic [RADDR-1:0] id_rs1;
    logic [RADDR-1:0] id_rs2;
    logic [RADDR-1:0] id_rd;
    logic [3:0]       id_alu_sel;
    logic             id_alu_src;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_mem_write;
    logic             id_mem_to_reg;
    logic             id_branch;
    logic             flush;

    // Forwarding sources from later pipeline stages
    logic             exmem_reg_write;
    logic [RADDR-1:0] exmem_rd;
    logic [XLEN-1:0]  exmem_result;
    logic             memwb_reg_write;
    logic [RADDR-1:0] memwb_rd;
    logic [XLEN-1:0]  memwb_result;

    // Stage outputs
    logic             stall;
    logic [XLEN-1:0]  ex_alu_a;
    logic [XLEN-1:0]  ex_alu_b;
    logic [3:0]       ex_alu_sel;
    logic [XLEN-1:0]  ex_store_data;
    logic [XLEN-1:0]  ex_pc;
    logic [RADDR-1:0] ex_rd;
    logic             ex_valid;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_mem_to_reg;
    logic             ex_branch;
    logic [CNT_W-1:0] bubble_count;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_sel, id_alu_src,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch,
               flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  stall, ex_alu_a, ex_alu_b, ex_alu_sel, ex_store_data, ex_pc, ex_rd,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_branch, bubble_count
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_alu_sel, id_alu_src,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch,
               flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output stall, ex_alu_a, ex_alu_b, ex_alu_sel, ex_store_data, ex_pc, ex_rd,
               ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_branch, bubble_count
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: load-use bubble insertion, flush squashing and
// EX/MEM > MEM/WB operand forwarding feeding the ALU, plus a bubble counter.
module id_ex_operand_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    id_ex_operand_stage_if.slave bus
);
    localparam logic [3:0] ALU_ADD = 4'b0010;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic [RADDR-1:0] rs1;
        logic [RADDR-1:0] rs2;
        logic [RADDR-1:0] rd;
        logic [3:0]       alu_sel;
        logic             alu_src;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             mem_to_reg;
        logic             branch;
    } ex_slot_t;

    ex_slot_t         r_ex;
    ex_slot_t         w_id_slot;
    ex_slot_t         w_bubble_slot;
    logic             w_load_use;
    logic             w_stall;
    logic             w_bubble;
    logic [CNT_W-1:0] r_bubble_count;
    logic [XLEN-1:0]  w_fwd_rs1;
    logic [XLEN-1:0]  w_fwd_rs2;

    // Newest producer wins; x0 is hardwired zero and must never be forwarded.
    function automatic logic [XLEN-1:0] forward_operand(
        input logic [RADDR-1:0] rs,
        input logic [XLEN-1:0]  reg_data,
        input logic             exmem_we,
        input logic [RADDR-1:0] exmem_rd,
        input logic [XLEN-1:0]  exmem_data,
        input logic             memwb_we,
        input logic [RADDR-1:0] memwb_rd,
        input logic [XLEN-1:0]  memwb_data
    );
        if (exmem_we && (exmem_rd != '0) && (exmem_rd == rs)) begin
            return exmem_data;
        end else if (memwb_we && (memwb_rd != '0) && (memwb_rd == rs)) begin
            return memwb_data;
        end
        return reg_data;
    endfunction

    // A load in EX cannot supply its data to the instruction right behind it.
    assign w_load_use = bus.id_valid & r_ex.valid & r_ex.mem_read & (r_ex.rd != '0)
                      & ((r_ex.rd == bus.id_rs1) | (r_ex.rd == bus.id_rs2));
    assign w_stall    = w_load_use & ~bus.flush;
    assign w_bubble   = w_stall | bus.flush;

    // NOTE: every field gets a default before selective overrides so no latch is inferred.
    always_comb begin
        w_id_slot            = '0;
        w_id_slot.valid      = bus.id_valid;
        w_id_slot.pc         = bus.id_pc;
        w_id_slot.rs1_data   = bus.id_rs1_data;
        w_id_slot.rs2_data   = bus.id_rs2_data;
        w_id_slot.imm        = bus.id_imm;
        w_id_slot.rs1        = bus.id_rs1;
        w_id_slot.rs2        = bus.id_rs2;
        w_id_slot.rd         = bus.id_rd;
        w_id_slot.alu_sel    = bus.id_alu_sel;
        w_id_slot.alu_src    = bus.id_alu_src;
        w_id_slot.reg_write  = bus.id_reg_write;
        w_id_slot.mem_read   = bus.id_mem_read;
        w_id_slot.mem_write  = bus.id_mem_write;
        w_id_slot.mem_to_reg = bus.id_mem_to_reg;
        w_id_slot.branch     = bus.id_branch;

        // A bubble is an architectural no-op: add with every side effect disabled.
        w_bubble_slot         = '0;
        w_bubble_slot.alu_sel = ALU_ADD;
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex <= '0;
        end else if (w_bubble) begin
            r_ex <= w_bubble_slot;
        end else begin
            r_ex <= w_id_slot;
        end
    end

    // Only bubbles that displace a real instruction are worth counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bubble_count <= '0;
        end else if (w_bubble && bus.id_valid && (r_bubble_count != '1)) begin
            r_bubble_count <= r_bubble_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_fwd_rs1 = forward_operand(r_ex.rs1, r_ex.rs1_data,
                                    bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                                    bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
        w_fwd_rs2 = forward_operand(r_ex.rs2, r_ex.rs2_data,
                                    bus.exmem_reg_write, bus.exmem_rd, bus.exmem_result,
                                    bus.memwb_reg_write, bus.memwb_rd, bus.memwb_result);
    end

    assign bus.stall         = w_stall;
    assign bus.ex_alu_a      = w_fwd_rs1;
    assign bus.ex_alu_b      = r_ex.alu_src ? r_ex.imm : w_fwd_rs2;
    assign bus.ex_alu_sel    = r_ex.alu_sel;
    assign bus.ex_store_data = w_fwd_rs2;
    assign bus.ex_pc         = r_ex.pc;
    assign bus.ex_rd         = r_ex.rd;
    assign bus.ex_valid      = r_ex.valid;
    assign bus.ex_reg_write  = r_ex.reg_write;
    assign bus.ex_mem_read   = r_ex.mem_read;
    assign bus.ex_mem_write  = r_ex.mem_write;
    assign bus.ex_mem_to_reg = r_ex.mem_to_reg;
    assign bus.ex_branch     = r_ex.branch;
    assign bus.bubble_count  = r_bubble_count;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomised and directed bench for id_ex_operand_stage, compared every
// falling edge against an instruction-level model of the EX slot.
module tb_id_ex_operand_stage;
    localparam int XLEN  = 32;
    localparam int RADDR = 5;
    localparam int CNT_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_operand_stage_if #(.XLEN(XLEN), .RADDR(RADDR), .CNT_W(CNT_W)) bus ();

    id_ex_operand_stage #(.XLEN(XLEN), .RADDR(RADDR), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Model: the instruction currently in EX, or nothing at all (a bubble).
    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc, rs1_data, rs2_data, imm;
        logic [RADDR-1:0] rs1, rs2, rd;
        logic [3:0]       sel;
        logic             src, rw, mr, mw, m2r, br;
    } slot_t;

    slot_t m = '0;
    int    m_cnt = 0;
    bit    cmp_en = 1'b0;

    function automatic bit model_stall();
        if (bus.flush || !bus.id_valid || !m.valid || !m.mr || m.rd == 0) return 1'b0;
        return (m.rd == bus.id_rs1) || (m.rd == bus.id_rs2);
    endfunction

    function automatic logic [XLEN-1:0] model_fwd(input logic [RADDR-1:0] rs,
                                                  input logic [XLEN-1:0] data);
        if (rs == 0) return data;
        if (bus.exmem_reg_write && bus.exmem_rd == rs) return bus.exmem_result;
        if (bus.memwb_reg_write && bus.memwb_rd == rs) return bus.memwb_result;
        return data;
    endfunction

    always @(posedge clk) begin
        automatic bit squash = bus.flush || model_stall();
        if (rst) begin
            m     = '0;
            m_cnt = 0;
        end else if (squash) begin
            m     = '0;
            m.sel = 4'b0010;
            if (bus.id_valid) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        end else begin
            m.valid    = bus.id_valid;
            m.pc       = bus.id_pc;
            m.rs1_data = bus.id_rs1_data;
            m.rs2_data = bus.id_rs2_data;
            m.imm      = bus.id_imm;
            m.rs1      = bus.id_rs1;
            m.rs2      = bus.id_rs2;
            m.rd       = bus.id_rd;
            m.sel      = bus.id_alu_sel;
            m.src      = bus.id_alu_src;
            m.rw       = bus.id_reg_write;
            m.mr       = bus.id_mem_read;
            m.mw       = bus.id_mem_write;
            m.m2r      = bus.id_mem_to_reg;
            m.br       = bus.id_branch;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            automatic logic [XLEN-1:0] fa = model_fwd(m.rs1, m.rs1_data);
            automatic logic [XLEN-1:0] fb = model_fwd(m.rs2, m.rs2_data);
            check("stall",        bus.stall,         model_stall());
            check("ex_valid",     bus.ex_valid,      m.valid);
            check("ex_alu_a",     bus.ex_alu_a,      fa);
            check("ex_alu_b",     bus.ex_alu_b,      m.src ? m.imm : fb);
            check("ex_store",     bus.ex_store_data, fb);
            check("ex_alu_sel",   bus.ex_alu_sel,    m.sel);
            check("ex_pc",        bus.ex_pc,         m.pc);
            check("ex_rd",        bus.ex_rd,         m.rd);
            check("ex_ctrl",      {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                                   bus.ex_mem_to_reg, bus.ex_branch},
                                  {m.rw, m.mr, m.mw, m.m2r, m.br});
            check("bubble_count", bus.bubble_count,  m_cnt[CNT_W-1:0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_valid = 0; bus.id_pc = '0; bus.id_rs1_data = '0; bus.id_rs2_data = '0;
        bus.id_imm = '0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
        bus.id_alu_sel = 4'b0010; bus.id_alu_src = 0; bus.id_reg_write = 0;
        bus.id_mem_read = 0; bus.id_mem_write = 0; bus.id_mem_to_reg = 0; bus.id_branch = 0;
        bus.flush = 0;
        bus.exmem_reg_write = 0; bus.exmem_rd = '0; bus.exmem_result = '0;
        bus.memwb_reg_write = 0; bus.memwb_rd = '0; bus.memwb_result = '0;
    endtask

    task automatic put_instr(input logic [XLEN-1:0] pc, input logic [RADDR-1:0] rs1, rs2, rd,
                             input logic [XLEN-1:0] d1, d2, input logic [3:0] sel,
                             input logic mr);
        bus.id_valid = 1; bus.id_pc = pc; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = '0; bus.id_alu_sel = sel;
        bus.id_alu_src = mr; bus.id_reg_write = 1; bus.id_mem_read = mr;
        bus.id_mem_to_reg = mr; bus.id_mem_write = 0; bus.id_branch = 0;
    endtask

    task automatic randomize_inputs();
        logic [3:0] sels [4] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};
        bus.id_valid        = ($urandom_range(0, 9) < 8);
        bus.id_pc           = $urandom;
        bus.id_rs1_data     = $urandom;
        bus.id_rs2_data     = $urandom;
        bus.id_imm          = $urandom;
        bus.id_rs1          = RADDR'($urandom_range(0, 7));
        bus.id_rs2          = RADDR'($urandom_range(0, 7));
        bus.id_rd           = RADDR'($urandom_range(0, 7));
        bus.id_alu_sel      = sels[$urandom_range(0, 3)];
        bus.id_alu_src      = $urandom_range(0, 1);
        bus.id_reg_write    = $urandom_range(0, 1);
        bus.id_mem_read     = ($urandom_range(0, 9) < 4);
        bus.id_mem_write    = $urandom_range(0, 1);
        bus.id_mem_to_reg   = $urandom_range(0, 1);
        bus.id_branch       = $urandom_range(0, 1);
        bus.flush           = ($urandom_range(0, 9) == 0);
        bus.exmem_reg_write = $urandom_range(0, 1);
        bus.exmem_rd        = RADDR'($urandom_range(0, 7));
        bus.exmem_result    = $urandom;
        bus.memwb_reg_write = $urandom_range(0, 1);
        bus.memwb_rd        = RADDR'($urandom_range(0, 7));
        bus.memwb_result    = $urandom;
        rst                 = ($urandom_range(0, 49) == 0);
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        step();
        step();
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset ex_valid", bus.ex_valid, 0);
        check("reset count", bus.bubble_count, 0);
        check("reset stall", bus.stall, 0);

        // add x3, x1, x2 straight through
        rst = 0;
        put_instr(32'h100, 1, 2, 3, 32'h10, 32'h20, 4'b0010, 0);
        step();
        clear_inputs();
        @(negedge clk);
        check("add alu_a", bus.ex_alu_a, 32'h10);
        check("add alu_b", bus.ex_alu_b, 32'h20);
        check("add sel", bus.ex_alu_sel, 4'b0010);
        check("add rd", bus.ex_rd, 3);
        check("add valid", bus.ex_valid, 1);

        // forwarding priority on rs1 = x5
        put_instr(32'h104, 5, 6, 9, 32'h1, 32'h2, 4'b0010, 0);
        step();
        clear_inputs();
        bus.exmem_reg_write = 1; bus.exmem_rd = 5; bus.exmem_result = 32'hAAAA;
        bus.memwb_reg_write = 1; bus.memwb_rd = 5; bus.memwb_result = 32'hBBBB;
        @(negedge clk);
        check("fwd exmem prio", bus.ex_alu_a, 32'hAAAA);
        bus.exmem_rd = 0;
        #1;
        check("fwd memwb", bus.ex_alu_a, 32'hBBBB);

        // x0 is never forwarded
        clear_inputs();
        put_instr(32'h108, 1, 0, 4, 32'h7, 32'h0, 4'b0010, 0);
        step();
        clear_inputs();
        bus.exmem_reg_write = 1; bus.exmem_rd = 0; bus.exmem_result = 32'h1234;
        @(negedge clk);
        check("x0 alu_b", bus.ex_alu_b, 0);
        check("x0 store", bus.ex_store_data, 0);

        // lw x7 then sub x8, x7, x1: exactly one bubble
        clear_inputs();
        put_instr(32'h10C, 2, 0, 7, 32'h40, 32'h0, 4'b0010, 1);
        step();
        put_instr(32'h110, 7, 1, 8, 32'h0, 32'h5, 4'b0110, 0);
        @(negedge clk);
        check("load-use stall", bus.stall, 1);
        step();
        @(negedge clk);
        check("after stall", bus.stall, 0);
        check("bubble valid", bus.ex_valid, 0);
        check("bubble count 1", bus.bubble_count, 1);
        step();
        clear_inputs();
        @(negedge clk);
        check("sub valid", bus.ex_valid, 1);
        check("sub sel", bus.ex_alu_sel, 4'b0110);
        check("sub rd", bus.ex_rd, 8);

        // four flushed instructions bring the count to 5, then reset mid-stream
        for (int i = 0; i < 4; i++) begin
            put_instr(32'h200 + 32'(i * 4), 1, 2, 3, 32'h1, 32'h2, 4'b0010, 0);
            bus.flush = 1;
            step();
        end
        clear_inputs();
        put_instr(32'h210, 1, 2, 3, 32'h1, 32'h2, 4'b0010, 0);
        step();
        clear_inputs();
        @(negedge clk);
        check("pre-reset valid", bus.ex_valid, 1);
        check("pre-reset count", bus.bubble_count, 5);
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        check("mid reset valid", bus.ex_valid, 0);
        check("mid reset count", bus.bubble_count, 0);
        check("mid reset alu_a", bus.ex_alu_a, 0);
        check("mid reset stall", bus.stall, 0);

        // flush beats a simultaneous load-use
        put_instr(32'h300, 2, 0, 7, 32'h40, 32'h0, 4'b0010, 1);
        step();
        put_instr(32'h304, 7, 1, 8, 32'h0, 32'h5, 4'b0110, 0);
        bus.flush = 1;
        #1;
        check("flush kills stall", bus.stall, 0);
        step();
        clear_inputs();
        @(negedge clk);
        check("flush bubble", bus.ex_valid, 0);
        check("flush count", bus.bubble_count, 1);

        for (int i = 0; i < 3000; i++) begin
            randomize_inputs();
            step();
        end

        // saturation
        clear_inputs();
        rst = 0;
        step();
        bus.id_valid = 1;
        bus.flush    = 1;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) step();
        @(negedge clk);
        check("count saturated", bus.bubble_count, 16'hFFFF);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
